// File: rtl/execute_stage.sv
// MIPS-32 execute stage: ALU, branch target, destination select and EX/MEM register,
// plus HI/LO and a 32-iteration shift-add signed multiplier that stalls the front end.
`timescale 1ns/1ps
module execute_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [1:0]  EX_in,
    input  logic [2:0]  M_in,
    input  logic [2:0]  WB_in,
    input  logic [3:0]  ALUop_in,
    input  logic [5:0]  funct_in,
    input  logic [31:0] Dato1,
    input  logic [31:0] Dato2,
    input  logic [31:0] Immediate,
    input  logic [31:0] Adder_in,
    input  logic [4:0]  Rt,
    input  logic [4:0]  Rd,
    input  logic [31:0] jump_address_in,
    output logic        stall,
    output logic [31:0] ALU_result,
    output logic        Zero,
    output logic [31:0] Branch_target,
    output logic [31:0] Store_data,
    output logic [4:0]  WriteReg,
    output logic [2:0]  M_out,
    output logic [2:0]  WB_out,
    output logic [31:0] jump_address_out,
    output logic        valid_out
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [63:0] acc_q;
    logic [63:0] mcand_q;
    logic [31:0] mplier_q;
    logic        neg_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic [31:0] op_b;
    logic [31:0] alu_res;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] product;
    logic        is_mult;

    assign is_mult = (ALUop_in == 4'b0010) && (funct_in == 6'b011000);
    // Depends only on decode fields and FSM state, never on operand data.
    assign stall   = is_mult && (state_q != DONE) && !flush;
    assign op_b    = EX_in[0] ? Immediate : Dato2;
    assign mag_a   = Dato1[31] ? (~Dato1 + 32'd1) : Dato1;
    assign mag_b   = Dato2[31] ? (~Dato2 + 32'd1) : Dato2;
    assign product = neg_q ? (~acc_q + 64'd1) : acc_q;

    always_comb begin
        alu_res = Dato1 + op_b;
        case (ALUop_in)
            4'b0001: alu_res = Dato1 - op_b;
            4'b0011: alu_res = Dato1 & op_b;
            4'b0100: alu_res = Dato1 | op_b;
            4'b0101: alu_res = {31'd0, $signed(Dato1) < $signed(op_b)};
            4'b0110: alu_res = {op_b[15:0], 16'd0};
            4'b0010: begin
                case (funct_in)
                    6'b100010: alu_res = Dato1 - op_b;
                    6'b100100: alu_res = Dato1 & op_b;
                    6'b100101: alu_res = Dato1 | op_b;
                    6'b100110: alu_res = Dato1 ^ op_b;
                    6'b100111: alu_res = ~(Dato1 | op_b);
                    6'b101010: alu_res = {31'd0, $signed(Dato1) < $signed(op_b)};
                    6'b010000: alu_res = hi_q;
                    6'b010010: alu_res = lo_q;
                    default:   alu_res = Dato1 + op_b;
                endcase
            end
            default: alu_res = Dato1 + op_b;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ALU_result       <= '0;
            Zero             <= 1'b0;
            Branch_target    <= '0;
            Store_data       <= '0;
            WriteReg         <= '0;
            M_out            <= '0;
            WB_out           <= '0;
            jump_address_out <= '0;
            valid_out        <= 1'b0;
            state_q          <= IDLE;
            cnt_q            <= '0;
            acc_q            <= '0;
            mcand_q          <= '0;
            mplier_q         <= '0;
            neg_q            <= 1'b0;
            hi_q             <= '0;
            lo_q             <= '0;
        end else begin
            ALU_result       <= alu_res;
            Zero             <= (alu_res == 32'd0);
            Branch_target    <= Adder_in + {Immediate[29:0], 2'b00};
            Store_data       <= Dato2;
            WriteReg         <= EX_in[1] ? Rd : Rt;
            jump_address_out <= jump_address_in;
            if (flush || stall) begin
                M_out     <= '0;
                WB_out    <= '0;
                valid_out <= 1'b0;
            end else begin
                M_out     <= M_in;
                // A committing mult writes HI/LO only, never the register file.
                WB_out    <= is_mult ? {1'b0, WB_in[1:0]} : WB_in;
                valid_out <= 1'b1;
            end

            if (flush) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: if (is_mult) begin
                        state_q  <= BUSY;
                        cnt_q    <= '0;
                        acc_q    <= '0;
                        mcand_q  <= {32'd0, mag_a};
                        mplier_q <= mag_b;
                        neg_q    <= Dato1[31] ^ Dato2[31];
                    end
                    BUSY: begin
                        if (mplier_q[0])
                            acc_q <= acc_q + mcand_q;
                        mcand_q  <= {mcand_q[62:0], 1'b0};
                        mplier_q <= {1'b0, mplier_q[31:1]};
                        cnt_q    <= cnt_q + 6'd1;
                        if (cnt_q == 6'd31)
                            state_q <= DONE;
                    end
                    DONE: begin
                        hi_q    <= product[63:32];
                        lo_q    <= product[31:0];
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// Randomized self-checking bench for execute_stage against an arithmetic reference model
// that tracks HI/LO and computes results directly from the instruction semantics.
`timescale 1ns/1ps
module tb_execute_stage;
    logic        clk = 1'b0;
    logic        rst, flush;
    logic [1:0]  EX_in;
    logic [2:0]  M_in, WB_in;
    logic [3:0]  ALUop_in;
    logic [5:0]  funct_in;
    logic [31:0] Dato1, Dato2, Immediate, Adder_in, jump_address_in;
    logic [4:0]  Rt, Rd;
    logic        stall;
    logic [31:0] ALU_result, Branch_target, Store_data, jump_address_out;
    logic        Zero, valid_out;
    logic [4:0]  WriteReg;
    logic [2:0]  M_out, WB_out;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    execute_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .EX_in(EX_in), .M_in(M_in), .WB_in(WB_in),
        .ALUop_in(ALUop_in), .funct_in(funct_in), .Dato1(Dato1), .Dato2(Dato2),
        .Immediate(Immediate), .Adder_in(Adder_in), .Rt(Rt), .Rd(Rd),
        .jump_address_in(jump_address_in), .stall(stall), .ALU_result(ALU_result),
        .Zero(Zero), .Branch_target(Branch_target), .Store_data(Store_data),
        .WriteReg(WriteReg), .M_out(M_out), .WB_out(WB_out),
        .jump_address_out(jump_address_out), .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h required %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [5:0] fn,
                                            input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        if (op == 4'd1) return a - b;
        if (op == 4'd3) return a & b;
        if (op == 4'd4) return a | b;
        if (op == 4'd5) return (sa < sb) ? 32'd1 : 32'd0;
        if (op == 4'd6) return b * 32'd65536;
        if (op == 4'd2) begin
            if (fn == 6'h22) return a - b;
            if (fn == 6'h24) return a & b;
            if (fn == 6'h25) return a | b;
            if (fn == 6'h26) return a ^ b;
            if (fn == 6'h27) return ~(a | b);
            if (fn == 6'h2A) return (sa < sb) ? 32'd1 : 32'd0;
            if (fn == 6'h10) return m_hi;
            if (fn == 6'h12) return m_lo;
        end
        return a + b;
    endfunction

    task automatic apply(input logic [3:0] op, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] d2, input logic [31:0] imm, input logic [31:0] pc,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [1:0] ex,
                         input logic [2:0] m, input logic [2:0] wb, input logic [31:0] jmp,
                         input logic fl);
        ALUop_in = op; funct_in = fn; Dato1 = a; Dato2 = d2; Immediate = imm; Adder_in = pc;
        Rt = rt; Rd = rd; EX_in = ex; M_in = m; WB_in = wb; jump_address_in = jmp; flush = fl;
    endtask

    // One non-mult instruction through EX; returns the expected ALU result.
    task automatic run_op(input logic [3:0] op, input logic [5:0] fn, input logic [31:0] a,
                          input logic [31:0] d2, input logic [31:0] imm, input logic [31:0] pc,
                          input logic [4:0] rt, input logic [4:0] rd, input logic [1:0] ex,
                          input logic [2:0] m, input logic [2:0] wb, input logic [31:0] jmp,
                          input logic fl, output logic [31:0] exp_res);
        logic [31:0] b;
        b = ex[0] ? imm : d2;
        exp_res = ref_alu(op, fn, a, b);
        apply(op, fn, a, d2, imm, pc, rt, rd, ex, m, wb, jmp, fl);
        #1;
        check_eq("stall_nonmult", 32'(stall), 32'd0);
        @(posedge clk); #1;
        if (fl) begin
            check_eq("flush_valid", 32'(valid_out), 32'd0);
            check_eq("flush_ctrl", {26'd0, M_out, WB_out}, 32'd0);
        end else begin
            check_eq("alu_result", ALU_result, exp_res);
            check_eq("zero", 32'(Zero), (exp_res == 32'd0) ? 32'd1 : 32'd0);
            check_eq("branch_target", Branch_target, pc + imm * 32'd4);
            check_eq("store_data", Store_data, d2);
            check_eq("writereg", 32'(WriteReg), 32'(ex[1] ? rd : rt));
            check_eq("m_wb_out", {26'd0, M_out, WB_out}, {26'd0, m, wb});
            check_eq("jump_out", jump_address_out, jmp);
            check_eq("valid", 32'(valid_out), 32'd1);
        end
        $display("op=%h fn=%h a=%08h b=%08h flush=%0d exp=%08h res=%08h",
                 op, fn, a, b, fl, exp_res, ALU_result);
        apply(4'd0, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 2'd0, 3'd0, 3'd0, 32'd0, 1'b0);
    endtask

    task automatic run_mult(input logic [31:0] a, input logic [31:0] b);
        int  cyc;
        longint p;
        apply(4'd2, 6'h18, a, b, 32'd0, 32'd0, 5'd3, 5'd9, 2'b10, 3'd0, 3'b101, 32'd0, 1'b0);
        #1;
        cyc = 0;
        while (stall === 1'b1 && cyc < 40) begin
            if (cyc > 0) check_eq("mult_bubble", {28'd0, valid_out, WB_out}, 32'd0);
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("mult_stall_cycles", 32'(cyc), 32'd33);
        @(posedge clk); #1;
        check_eq("mult_commit_valid", 32'(valid_out), 32'd1);
        check_eq("mult_commit_wb", 32'(WB_out), 32'b001);
        p = longint'(int'(a)) * longint'(int'(b));
        m_hi = p[63:32];
        m_lo = p[31:0];
        $display("mult a=%08h b=%08h stall_cycles=%0d hi=%08h lo=%08h", a, b, cyc, m_hi, m_lo);
        apply(4'd0, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 2'd0, 3'd0, 3'd0, 32'd0, 1'b0);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] old_hi, old_lo;
        logic [3:0]  op;
        logic [5:0]  fn;
        logic [5:0]  fn_list [9];
        fn_list = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h10, 6'h12};

        rst = 1'b1;
        apply(4'd0, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 2'd0, 3'd0, 3'd0, 32'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_valid", 32'(valid_out), 32'd0);
        check_eq("reset_alu", ALU_result, 32'd0);
        check_eq("reset_stall", 32'(stall), 32'd0);
        rst = 1'b0;

        // Directed cases with hand-derived values.
        run_op(4'd2, 6'h22, 32'd5, 32'd7, 32'd0, 32'd0, 5'd4, 5'd12, 2'b10, 3'd0, 3'b100, 32'd0, 1'b0, r);
        check_eq("sub_const", ALU_result, 32'hFFFFFFFE);
        check_eq("sub_rd", 32'(WriteReg), 32'd12);
        run_op(4'd2, 6'h2A, 32'd5, 32'd7, 32'd0, 32'd0, 5'd4, 5'd12, 2'b10, 3'd0, 3'b100, 32'd0, 1'b0, r);
        check_eq("slt_const", ALU_result, 32'd1);
        run_op(4'd1, 6'd0, 32'h1234, 32'h1234, 32'hFFFFFFFC, 32'h00400010, 5'd1, 5'd2, 2'b00,
               3'b100, 3'd0, 32'd0, 1'b0, r);
        check_eq("beq_zero", 32'(Zero), 32'd1);
        check_eq("beq_target", Branch_target, 32'h00400000);
        run_op(4'd6, 6'd0, 32'd0, 32'd0, 32'h0000ABCD, 32'd0, 5'd8, 5'd20, 2'b01, 3'd0, 3'b100,
               32'd0, 1'b0, r);
        check_eq("lui_const", ALU_result, 32'hABCD0000);
        check_eq("lui_rt", 32'(WriteReg), 32'd8);

        run_mult(32'hFFFFFFFD, 32'd7);
        run_op(4'd2, 6'h10, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd1, 2'b10, 3'd0, 3'b100, 32'd0, 1'b0, r);
        check_eq("mfhi_const", ALU_result, 32'hFFFFFFFF);
        run_op(4'd2, 6'h12, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd1, 2'b10, 3'd0, 3'b100, 32'd0, 1'b0, r);
        check_eq("mflo_const", ALU_result, 32'hFFFFFFEB);

        // Flush in cycle 10 of a mult: bubble, no stall, HI/LO untouched.
        old_hi = m_hi;
        old_lo = m_lo;
        apply(4'd2, 6'h18, 32'h12345, 32'h6789A, 32'd0, 32'd0, 5'd3, 5'd9, 2'b10, 3'd0, 3'b101, 32'd0, 1'b0);
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1;
        #1;
        check_eq("flush_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        check_eq("flush_bubble", {28'd0, valid_out, WB_out}, 32'd0);
        run_op(4'd2, 6'h10, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd1, 2'b10, 3'd0, 3'b100, 32'd0, 1'b0, r);
        check_eq("flush_hi_kept", ALU_result, old_hi);
        run_op(4'd2, 6'h12, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd1, 2'b10, 3'd0, 3'b100, 32'd0, 1'b0, r);
        check_eq("flush_lo_kept", ALU_result, old_lo);

        // Randomized mix of ALU ops, HI/LO reads, mults and flushed slots.
        for (int i = 0; i < 150; i++) begin
            int sel;
            sel = int'($urandom_range(0, 19));
            if (sel == 0) begin
                run_mult($urandom_range(0, 3) == 0 ? 32'h80000000 : $urandom(),
                         $urandom_range(0, 3) == 0 ? 32'hFFFFFFFF : $urandom());
            end else begin
                op = 4'($urandom_range(0, 15));
                fn = fn_list[$urandom_range(0, 8)];
                if ($urandom_range(0, 4) == 0) fn = 6'($urandom_range(0, 63));
                if (fn == 6'h18) fn = 6'h20;
                if (sel == 1) begin op = 4'd2; fn = ($urandom_range(0, 1) == 0) ? 6'h10 : 6'h12; end
                run_op(op, fn, $urandom(), ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom(),
                       $urandom(), $urandom(), 5'($urandom()), 5'($urandom()), 2'($urandom()),
                       3'($urandom()), 3'($urandom()), $urandom(), $urandom_range(0, 9) == 0, r);
            end
        end

        // Reset with a mult in flight after HI was made nonzero.
        run_mult(32'h80000000, 32'h7FFFFFFF);
        apply(4'd2, 6'h18, 32'd99, 32'd77, 32'd0, 32'd0, 5'd3, 5'd9, 2'b10, 3'd0, 3'b101, 32'd0, 1'b0);
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_alu", ALU_result, 32'd0);
        check_eq("rst_zero", 32'(Zero), 32'd0);
        check_eq("rst_target", Branch_target, 32'd0);
        check_eq("rst_store", Store_data, 32'd0);
        check_eq("rst_writereg", 32'(WriteReg), 32'd0);
        check_eq("rst_ctrl", {26'd0, M_out, WB_out}, 32'd0);
        check_eq("rst_jump", jump_address_out, 32'd0);
        check_eq("rst_valid", 32'(valid_out), 32'd0);
        rst = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        run_op(4'd2, 6'h10, 32'd5, 32'd6, 32'd0, 32'd0, 5'd0, 5'd1, 2'b10, 3'd0, 3'b100, 32'd0, 1'b0, r);
        check_eq("rst_mfhi", ALU_result, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the 5-stage MIPS-32 pipeline. Consumes the registered ID/EX outputs of the decode stage, computes the ALU result, the branch target and the destination register, and registers them into the EX/MEM pipeline buffer. Contains the HI/LO pair and an iterative signed multiplier for `mult`. While the multiplier runs, the block stalls the front of the pipeline.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: kills the instruction currently in EX; it becomes a bubble.
- `EX_in` in 2: {RegDst, ALUSrc}.
- `M_in` in 3: {Branch, MemRead, MemWrite}.
- `WB_in` in 3: {RegWrite, MemtoReg, Jump}.
- `ALUop_in` in 4: ALU operation class.
- `funct_in` in 6: instruction funct field.
- `Dato1` in 32: rs value.
- `Dato2` in 32: rt value.
- `Immediate` in 32: sign-extended immediate.
- `Adder_in` in 32: PC+4.
- `Rt`, `Rd` in 5 each: candidate destination registers.
- `jump_address_in` in 32: jump target.
- `stall` out 1: combinational; freezes PC, IF/ID and ID/EX while high.
- `ALU_result` out 32: registered.
- `Zero` out 1: registered; ALU result == 0.
- `Branch_target` out 32: registered.
- `Store_data` out 32: registered Dato2.
- `WriteReg` out 5: registered destination register.
- `M_out` out 3, `WB_out` out 3: registered control bits.
- `jump_address_out` out 32: registered.
- `valid_out` out 1: registered; 1 = real instruction in EX/MEM.

## Operation
- Operand B is `Immediate` when ALUSrc = 1, otherwise `Dato2`. `WriteReg` is `Rd` when RegDst = 1, otherwise `Rt`.
- `Branch_target` = `Adder_in` + (`Immediate` << 2), mod 2^32.
- ALUop codes:
  - 0000 add
  - 0001 sub
  - 0011 and
  - 0100 or
  - 0101 slt (signed)
  - 0110 lui: B << 16
  - 0010 R-type, decoded by funct
  - any other code: add
- R-type funct codes:
  - 100000 add
  - 100010 sub
  - 100100 and
  - 100101 or
  - 100110 xor
  - 100111 nor
  - 101010 slt
  - 010000 mfhi
  - 010010 mflo
  - 011000 mult
  - any other funct: add
- Add and sub wrap mod 2^32. There is no overflow trap.
- mult is signed 32x32 -> 64.
  - Take the magnitudes of both operands.
  - Run 32 shift-add iterations, one per clock.
  - Negate the 64-bit product if the operand signs differ.
  - Write HI = [63:32], LO = [31:0].
- FSM states: IDLE, BUSY, DONE.
  - IDLE -> BUSY when a mult is presented and `flush` = 0. Operands are latched and the counter is set to 0.
  - In BUSY, the counter increments each edge. BUSY -> DONE after the 32nd iteration.
  - DONE -> IDLE on the next edge. On that edge HI/LO are written and EX/MEM takes the mult with RegWrite forced to 0.
- `stall` = mult present AND state != DONE.
- While `stall` is high, EX/MEM loads a bubble every edge: M_out = 0, WB_out = 0, valid_out = 0.
- `flush` in any state:
  - EX/MEM loads a bubble.
  - The FSM returns to IDLE.
  - HI/LO are unchanged.
  - `stall` is forced to 0.
  - Priority: `rst` > `flush` > normal operation.
- `rst`:
  - All registered outputs go to 0: `ALU_result`, `Zero`, `Branch_target`, `Store_data`, `WriteReg`, `M_out`, `WB_out`, `jump_address_out`, `valid_out`.
  - HI and LO go to 0.
  - The FSM goes to IDLE and the counter to 0.
  - A mult in progress is abandoned.
- mfhi/mflo read the committed HI/LO. A mult followed directly by mfhi returns the new product, because the stall holds mfhi in ID until the commit.

## Timing
- Non-mult instructions have a latency of 1: inputs in cycle n appear on the outputs after the edge ending cycle n.
- mult presented in cycle 0:
  - `stall` is high in cycles 0..32 (33 cycles).
  - The edge ending cycle 0 latches the operands.
  - The edges ending cycles 1..32 perform iterations 1..32.
  - Cycle 33: `stall` is low. The edge ending cycle 33 commits HI/LO and the next instruction enters EX.
- `stall` depends combinationally on `ALUop_in`, `funct_in`, the FSM state and `flush`. There is no combinational path from `Dato1`/`Dato2` to `stall`.
- `Zero` is computed from the same result that is written to `ALU_result`.
- Back-to-back mults: the second mult enters IDLE -> BUSY on the edge after the first commits. There is no idle gap.

## Test plan
- Reset: assert `rst` with a nonzero mult in flight -> all outputs 0, `stall` = 0 on the next cycle, a following mfhi returns 0.
- R-type sub with `Dato1` = 5, `Dato2` = 7 -> `ALU_result` = 0xFFFFFFFE, `Zero` = 0. slt on the same operands -> 1. `WriteReg` = `Rd` with RegDst = 1.
- beq-style ALUop = 0001 with `Dato1` = `Dato2` = 0x1234, `Adder_in` = 0x00400010, `Immediate` = 0xFFFFFFFC -> `Zero` = 1, `Branch_target` = 0x00400000.
- mult 0xFFFFFFFD x 7, then mfhi, then mflo -> `stall` high for exactly 33 cycles, mfhi = 0xFFFFFFFF, mflo = 0xFFFFFFEB.
- `flush` asserted at cycle 10 of a mult -> bubble into EX/MEM, `stall` low in that cycle, HI/LO keep their prior values.
- lui with `Immediate` = 0x0000ABCD, ALUSrc = 1 -> `ALU_result` = 0xABCD0000, `WriteReg` = `Rt`, `valid_out` = 1.
